// File: rtl/contour_stats.sv
`default_nettype none
// ============================================================================
// Module   : contour_stats
// Purpose  : Raster-scans the edge BRAM once and measures the labelled contour:
//            pixel count, bounding box and integer centroid.
// Revision : 1.0  initial release
// ============================================================================
module contour_stats #(
    parameter int          WIDTH        = 640,
    parameter int          HEIGHT       = 480,
    parameter logic [2:0]  LABEL        = 3'b001,
    parameter int          READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  bram_read,
    output logic [18:0] edge_addr_read,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [18:0] count,
    output logic [9:0]  x_min,
    output logic [9:0]  x_max,
    output logic [8:0]  y_min,
    output logic [8:0]  y_max,
    output logic [9:0]  x_center,
    output logic [8:0]  y_center
);

    localparam logic [18:0] c_last_addr  = 19'(WIDTH * HEIGHT - 1);
    localparam logic [9:0]  c_x_last     = 10'(WIDTH - 1);
    localparam logic [8:0]  c_y_last     = 9'(HEIGHT - 1);
    localparam logic [3:0]  c_drain_last = 4'(READ_LATENCY - 1);
    localparam logic [4:0]  c_div_last   = 5'd27;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_DRAIN = 3'd2,
        S_DIV_X = 3'd3,
        S_DIV_Y = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t r_state, w_next;

    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [9:0]  r_xp [READ_LATENCY];
    logic [8:0]  r_yp [READ_LATENCY];
    logic        r_vp [READ_LATENCY];
    logic [3:0]  r_drain;

    logic [18:0] r_cnt;
    logic [27:0] r_sx, r_sy;
    logic [9:0]  r_xmin, r_xmax;
    logic [8:0]  r_ymin, r_ymax;

    logic [27:0] r_quo;
    logic [18:0] r_rem;
    logic [4:0]  r_bit;
    logic [9:0]  r_xq;
    logic [8:0]  r_yq;

    logic        w_hit;
    logic [9:0]  w_x_al;
    logic [8:0]  w_y_al;
    logic [18:0] w_cnt_next;
    logic [27:0] w_sx_next, w_sy_next;
    logic [19:0] w_trial;
    logic        w_ge;
    logic [18:0] w_rem_step;
    logic [27:0] w_quo_step;

    // Coordinates delayed to line up with the BRAM data for the same address
    assign w_x_al     = r_xp[READ_LATENCY-1];
    assign w_y_al     = r_yp[READ_LATENCY-1];
    assign w_hit      = r_vp[READ_LATENCY-1] && (bram_read == LABEL);
    assign w_cnt_next = r_cnt + 19'(w_hit);
    assign w_sx_next  = r_sx + (w_hit ? 28'(w_x_al) : 28'd0);
    assign w_sy_next  = r_sy + (w_hit ? 28'(w_y_al) : 28'd0);

    // One restoring-division step; remainder stays below cnt so 19 bits suffice
    assign w_trial    = {r_rem, r_quo[27]};
    assign w_ge       = (w_trial >= {1'b0, r_cnt});
    assign w_rem_step = w_ge ? (w_trial[18:0] - r_cnt) : w_trial[18:0];
    assign w_quo_step = {r_quo[26:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SCAN;
            S_SCAN:  if (edge_addr_read == c_last_addr) w_next = S_DRAIN;
            S_DRAIN: if (r_drain == c_drain_last)
                         w_next = (w_cnt_next == 19'd0) ? S_DONE : S_DIV_X;
            S_DIV_X: if (r_bit == c_div_last) w_next = S_DIV_Y;
            S_DIV_Y: if (r_bit == c_div_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_addr_read <= '0;
            busy <= 1'b0;  done  <= 1'b0;  valid <= 1'b0;  count <= '0;
            x_min <= '0;   x_max <= '0;    y_min <= '0;    y_max <= '0;
            x_center <= '0; y_center <= '0;
            r_x <= '0;  r_y <= '0;  r_drain <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_xp[i] <= '0;  r_yp[i] <= '0;  r_vp[i] <= 1'b0;
            end
            r_cnt <= '0;  r_sx <= '0;  r_sy <= '0;
            r_xmin <= c_x_last;  r_xmax <= '0;  r_ymin <= c_y_last;  r_ymax <= '0;
            r_quo <= '0;  r_rem <= '0;  r_bit <= '0;  r_xq <= '0;  r_yq <= '0;
        end else begin
            busy <= (r_state != S_IDLE);
            done <= 1'b0;

            r_xp[0] <= r_x;
            r_yp[0] <= r_y;
            r_vp[0] <= (r_state == S_SCAN);
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_xp[i] <= r_xp[i-1];  r_yp[i] <= r_yp[i-1];  r_vp[i] <= r_vp[i-1];
            end

            if (w_hit) begin
                r_cnt <= w_cnt_next;
                r_sx  <= w_sx_next;
                r_sy  <= w_sy_next;
                if (w_x_al < r_xmin) r_xmin <= w_x_al;
                if (w_x_al > r_xmax) r_xmax <= w_x_al;
                if (w_y_al < r_ymin) r_ymin <= w_y_al;
                if (w_y_al > r_ymax) r_ymax <= w_y_al;
            end

            case (r_state)
                S_IDLE: if (start) begin
                    r_cnt <= '0;  r_sx <= '0;  r_sy <= '0;
                    r_xmin <= c_x_last;  r_xmax <= '0;
                    r_ymin <= c_y_last;  r_ymax <= '0;
                end
                S_SCAN: begin
                    r_drain <= '0;
                    if (edge_addr_read == c_last_addr) begin
                        edge_addr_read <= '0;  r_x <= '0;  r_y <= '0;
                    end else begin
                        edge_addr_read <= edge_addr_read + 19'd1;
                        if (r_x == c_x_last) begin
                            r_x <= '0;
                            r_y <= r_y + 9'd1;
                        end else begin
                            r_x <= r_x + 10'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    r_drain <= r_drain + 4'd1;
                    r_quo   <= w_sx_next;
                    r_rem   <= '0;
                    r_bit   <= '0;
                end
                S_DIV_X: begin
                    r_bit <= r_bit + 5'd1;
                    r_quo <= w_quo_step;
                    r_rem <= w_rem_step;
                    if (r_bit == c_div_last) begin
                        r_xq  <= w_quo_step[9:0];
                        r_quo <= r_sy;
                        r_rem <= '0;
                        r_bit <= '0;
                    end
                end
                S_DIV_Y: begin
                    r_bit <= r_bit + 5'd1;
                    r_quo <= w_quo_step;
                    r_rem <= w_rem_step;
                    if (r_bit == c_div_last) r_yq <= w_quo_step[8:0];
                end
                S_DONE: begin
                    done  <= 1'b1;
                    count <= r_cnt;
                    valid <= (r_cnt != 19'd0);
                    if (r_cnt != 19'd0) begin
                        x_min <= r_xmin;  x_max <= r_xmax;
                        y_min <= r_ymin;  y_max <= r_ymax;
                        x_center <= r_xq; y_center <= r_yq;
                    end else begin
                        x_min <= '0;  x_max <= '0;  y_min <= '0;  y_max <= '0;
                        x_center <= '0;  y_center <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
